// File: rtl/uart_txq.sv
// uart_txq: queue-draining UART transmitter.
//
// Pulls bytes from a FIFO read port whenever CTS allows and sends each one
// as an asynchronous frame: a start bit, 8 data bits LSB first, an optional
// parity bit, and one or two stop bits. The frame format and bit period are
// sampled at dequeue time and held for the whole frame.
//
// Ports
//   clk6x         system clock
//   resetn        synchronous active-low reset
//   fifo_data_i   FIFO head byte (valid while fifo_empty_i=0)
//   fifo_empty_i  FIFO empty flag
//   fifo_rdeq_o   dequeue strobe, one cycle per byte taken
//   baud_div_i    bit period minus one, in clk6x cycles
//   parity_en_i   append a parity bit
//   parity_odd_i  1 = odd parity, 0 = even parity
//   two_stop_i    send two stop bits
//   cts_n_i       clear-to-send, active low, asynchronous
//   txd_o         serial output, idle high, registered
//   busy_o        frame in progress
//   frame_done_o  one-cycle pulse in the first idle cycle after a frame
module uart_txq #(
    parameter int DIVBITS = 16
) (
    input  logic               clk6x,
    input  logic               resetn,
    input  logic [7:0]         fifo_data_i,
    input  logic               fifo_empty_i,
    output logic               fifo_rdeq_o,
    input  logic [DIVBITS-1:0] baud_div_i,
    input  logic               parity_en_i,
    input  logic               parity_odd_i,
    input  logic               two_stop_i,
    input  logic               cts_n_i,
    output logic               txd_o,
    output logic               busy_o,
    output logic               frame_done_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state, state_d;
    logic [7:0]         shreg, shreg_d;
    logic [DIVBITS-1:0] div_lat, div_lat_d;
    logic [DIVBITS-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]         bit_cnt, bit_cnt_d;
    logic               stop_cnt, stop_cnt_d;
    logic               par_en, par_en_d;
    logic               par_bit, par_bit_d;
    logic               two_stop, two_stop_d;
    logic               txd_d, busy_d, done_d;
    logic               cts_s1, cts_s2;
    logic               bit_end;

    // Last cycle of the current bit period.
    assign bit_end = (baud_cnt == '0);

    // fifo_rdeq_o is driven from here, so it only depends on registered
    // state, the synchronized CTS and the empty flag.
    always_comb begin
        state_d      = state;
        shreg_d      = shreg;
        div_lat_d    = div_lat;
        baud_cnt_d   = baud_cnt;
        bit_cnt_d    = bit_cnt;
        stop_cnt_d   = stop_cnt;
        par_en_d     = par_en;
        par_bit_d    = par_bit;
        two_stop_d   = two_stop;
        txd_d        = txd_o;
        done_d       = 1'b0;
        fifo_rdeq_o  = 1'b0;

        // Count down within a bit; each state reloads on bit_end.
        if (state != IDLE && !bit_end)
            baud_cnt_d = baud_cnt - DIVBITS'(1);

        case (state)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty_i && !cts_s2) begin
                    fifo_rdeq_o = 1'b1;
                    shreg_d     = fifo_data_i;
                    div_lat_d   = baud_div_i;
                    par_en_d    = parity_en_i;
                    // Parity computed once from the dequeued byte.
                    par_bit_d   = (^fifo_data_i) ^ parity_odd_i;
                    two_stop_d  = two_stop_i;
                    baud_cnt_d  = baud_div_i;
                    bit_cnt_d   = 3'd0;
                    stop_cnt_d  = 1'b0;
                    txd_d       = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_cnt_d = div_lat;
                    txd_d      = shreg[0];
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = div_lat;
                    if (bit_cnt == 3'd7) begin
                        if (par_en) begin
                            txd_d   = par_bit;
                            state_d = PARITY;
                        end else begin
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = STOP;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                        shreg_d   = {1'b0, shreg[7:1]};
                        txd_d     = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_cnt_d = div_lat;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (two_stop && !stop_cnt) begin
                        baud_cnt_d = div_lat;
                        stop_cnt_d = 1'b1;
                    end else begin
                        txd_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state        <= IDLE;
            shreg        <= '0;
            div_lat      <= '0;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            par_en       <= 1'b0;
            par_bit      <= 1'b0;
            two_stop     <= 1'b0;
            txd_o        <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            cts_s1       <= 1'b1;
            cts_s2       <= 1'b1;
        end else begin
            state        <= state_d;
            shreg        <= shreg_d;
            div_lat      <= div_lat_d;
            baud_cnt     <= baud_cnt_d;
            bit_cnt      <= bit_cnt_d;
            stop_cnt     <= stop_cnt_d;
            par_en       <= par_en_d;
            par_bit      <= par_bit_d;
            two_stop     <= two_stop_d;
            txd_o        <= txd_d;
            busy_o       <= busy_d;
            frame_done_o <= done_d;
            cts_s1       <= cts_n_i;
            cts_s2       <= cts_s1;
        end
    end

endmodule

// File: tb/tb_uart_txq.sv
module tb_uart_txq;

    logic        clk6x = 1'b0;
    logic        resetn;
    logic [7:0]  fifo_data_i;
    logic        fifo_empty_i;
    logic        fifo_rdeq_o;
    logic [15:0] baud_div_i;
    logic        parity_en_i;
    logic        parity_odd_i;
    logic        two_stop_i;
    logic        cts_n_i;
    logic        txd_o;
    logic        busy_o;
    logic        frame_done_o;

    uart_txq #(.DIVBITS(16)) dut (
        .clk6x        (clk6x),
        .resetn       (resetn),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rdeq_o  (fifo_rdeq_o),
        .baud_div_i   (baud_div_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .two_stop_i   (two_stop_i),
        .cts_n_i      (cts_n_i),
        .txd_o        (txd_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk6x = ~clk6x;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] div;
        bit          pe;
        bit          odd;
        bit          ts;
    } frame_t;

    logic [7:0] fifo_q[$];
    frame_t     exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    bit         last_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {txd_o, busy_o, frame_done_o, fifo_rdeq_o};
    endfunction

    task automatic update_fifo();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_data_i  = fifo_empty_i ? 8'h00 : fifo_q[0];
    endtask

    // Push a byte into the FIFO model and its expected frame (using the
    // configuration currently on the inputs) into the scoreboard.
    task automatic push(input logic [7:0] b);
        frame_t f;
        f.data = b; f.div = baud_div_i; f.pe = parity_en_i;
        f.odd = parity_odd_i; f.ts = two_stop_i;
        fifo_q.push_back(b);
        exp_q.push_back(f);
        update_fifo();
        #1;
    endtask

    // One clock: note the dequeue strobe before the edge, pop the FIFO model
    // after it, then let combinational outputs settle.
    task automatic tick();
        logic rd;
        @(negedge clk6x);
        rd = fifo_rdeq_o;
        @(posedge clk6x);
        #1;
        if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        last_rd = rd;
        update_fifo();
        #1;
    endtask

    task automatic wait_deq(input string tag, input int limit, output int n);
        n = 0;
        last_rd = 1'b0;
        while (!last_rd && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_deq"}, 32'(last_rd), 32'd1);
    endtask

    // Called right after the dequeue edge; checks every cycle of the frame
    // and the frame_done cycle. act 1 raises cts_n, act 2 sets baud_div=7,
    // both at frame cycle act_k.
    task automatic check_frame(input bit exp_rd_done, input int act_k, input int act);
        frame_t     f;
        logic [11:0] bits;
        int P, L;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        f = exp_q.pop_front();
        P = int'(f.div) + 1;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
        if (f.pe) bits[9] = (^f.data) ^ f.odd;
        L = (10 + int'(f.pe) + int'(f.ts)) * P;
        for (int k = 0; k < L; k++) begin
            if (k == act_k && act == 1) cts_n_i = 1'b1;
            if (k == act_k && act == 2) baud_div_i = 16'd7;
            #1;
            chk($sformatf("frame_%02h_cyc%0d", f.data, k), 32'(outs()),
                32'({bits[k/P], 1'b1, 1'b0, 1'b0}));
            tick();
        end
        chk($sformatf("frame_%02h_done", f.data), 32'(outs()),
            32'({1'b1, 1'b0, 1'b1, exp_rd_done}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0; cts_n_i = 1'b1; baud_div_i = 16'd3;
        parity_en_i = 1'b0; parity_odd_i = 1'b0; two_stop_i = 1'b0;
        update_fifo();
        repeat (3) tick();
        chk("reset_outs", 32'(outs()), 32'b1000);
        chk("reset_state", 32'(dut.state), 32'd0);
        resetn = 1'b1;
        tick();

        // Basic frame: 0x55, 4 clk/bit, 40 clk.
        cts_n_i = 1'b0;
        push(8'h55);
        wait_deq("basic", 10, n);
        check_frame(1'b0, -1, 0);
        tick();
        chk("basic_done_pulse", 32'(frame_done_o), 32'd0);

        // Parity and two stop bits: 24 clk frames.
        baud_div_i = 16'd1; parity_en_i = 1'b1; two_stop_i = 1'b1;
        push(8'h07);
        wait_deq("even", 10, n);
        check_frame(1'b0, -1, 0);
        parity_odd_i = 1'b1;
        push(8'h07);
        wait_deq("odd", 10, n);
        check_frame(1'b0, -1, 0);

        // Back-to-back.
        baud_div_i = 16'd2; parity_en_i = 1'b0; parity_odd_i = 1'b0; two_stop_i = 1'b0;
        push(8'hA5);
        push(8'h3C);
        wait_deq("b2b_a", 10, n);
        check_frame(1'b1, -1, 0);
        wait_deq("b2b_b", 10, n);
        chk("b2b_gap", 32'(n), 32'd1);
        check_frame(1'b0, -1, 0);

        // Flow control.
        baud_div_i = 16'd1;
        cts_n_i = 1'b1;
        repeat (3) tick();
        push(8'h96);
        push(8'h11);
        for (int i = 0; i < 100; i++) begin
            chk("cts_hold", 32'({txd_o, fifo_rdeq_o}), 32'b10);
            tick();
        end
        cts_n_i = 1'b0;
        tick();
        chk("cts_e1", 32'(fifo_rdeq_o), 32'd0);
        tick();
        chk("cts_e2", 32'(fifo_rdeq_o), 32'd1);
        wait_deq("cts", 3, n);
        check_frame(1'b0, 9, 1);
        for (int i = 0; i < 20; i++) begin
            chk("cts_block", 32'(fifo_rdeq_o), 32'd0);
            tick();
        end

        // Reset mid-frame during data bit 4; byte 0x11 is lost.
        cts_n_i = 1'b0;
        wait_deq("rst", 10, n);
        void'(exp_q.pop_front());
        repeat (11) tick();
        chk("rst_pre_busy", 32'(busy_o), 32'd1);
        resetn = 1'b0;
        tick();
        chk("rst_mid", 32'(outs()), 32'b1000);
        resetn = 1'b1;
        baud_div_i = 16'd2;
        push(8'h5A);
        wait_deq("post_rst", 10, n);
        check_frame(1'b0, -1, 0);

        // Minimum divisor; mid-frame divisor change must not take effect.
        baud_div_i = 16'd0;
        push(8'hFF);
        wait_deq("min", 10, n);
        check_frame(1'b0, 3, 2);
        push(8'h81);
        wait_deq("div7", 3, n);
        check_frame(1'b0, -1, 0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_txq.md
# uart_txq

Queue-draining UART transmitter for the NORA serial path. It reads bytes from an 8-bit FIFO read port (data, empty flag, dequeue strobe) and shifts each byte out on a TX line as an asynchronous frame. Each frame carries a programmable bit period, optional parity and one or two stop bits. A CTS input provides hardware flow control, and the block sits between the CPU-facing TX FIFO and the board TX pin.

## Interface
- DIVBITS, 16: width of the baud divisor.
- clk6x  in  1  system clock, 48 MHz. Already decided.
- resetn  in  1  synchronous, active-low reset. Already decided.
- fifo_data_i  in  8  FIFO read-port data; valid whenever fifo_empty_i=0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_rdeq_o  out  1  dequeue strobe, one clk6x cycle per byte taken.
- baud_div_i  in  DIVBITS  bit period = baud_div_i+1 clk6x cycles.
- parity_en_i  in  1  1 = append parity bit.
- parity_odd_i  in  1  1 = odd parity, 0 = even.
- two_stop_i  in  1  1 = two stop bits.
- cts_n_i  in  1  clear-to-send, active low, asynchronous.
- txd_o  out  1  serial output; idle high, registered.
- busy_o  out  1  1 while a frame is in progress (not IDLE).
- frame_done_o  out  1  one-cycle pulse when a frame completes.

## Operation
- cts_n_i passes through a 2-flop synchronizer. Both sync flops reset to 1 (not clear to send).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - txd_o=1.
  - Dequeue condition: fifo_empty_i=0 and synced CTS low.
  - When the condition holds, fifo_rdeq_o=1 for that cycle (combinational from registered state, sync flop and fifo_empty_i).
  - In the same cycle: fifo_data_i is captured into the shift register; baud_div_i, parity_en_i, parity_odd_i and two_stop_i are latched; the FSM moves to START.
- START: txd_o=0 for one bit period, then DATA.
- DATA:
  - 8 bits are sent LSB first, one bit period each.
  - A 3-bit counter tracks the bits.
  - After bit 7: go to PARITY if latched parity_en, else STOP.
- PARITY: one bit period.
  - Even parity: bit = XOR of the 8 data bits.
  - Odd parity: bit = inverted XOR.
- STOP:
  - txd_o=1 for 1 or 2 bit periods, per latched two_stop.
  - After the final stop cycle, frame_done_o pulses and the FSM returns to IDLE.
- Bit period: a DIVBITS-wide down-counter loads the latched divisor at each bit start and advances the bit at 0. baud_div_i=0 gives a 1-cycle bit, which is legal.
- Configuration inputs changing mid-frame have no effect until the next dequeue.
- CTS is checked only in IDLE. CTS deasserting mid-frame does not stop the current frame; it only blocks the next dequeue.
- fifo_rdeq_o is never asserted when fifo_empty_i=1 or outside IDLE.
- Reset mid-frame aborts the frame. Next cycle: txd_o=1, state IDLE. The dequeued byte is lost.

## Timing
- Reset values:
  - txd_o=1, fifo_rdeq_o=0, busy_o=0, frame_done_o=0.
  - State IDLE, counters 0, CTS sync flops 1.
- Dequeue-to-start latency: the dequeue happens at edge E0. From E0, txd_o=0 and busy_o=1.
- Frame length, with P = baud_div+1:
  - (10 + parity_en + two_stop) × P clk6x cycles from the start edge to the end of the last stop bit.
  - frame_done_o is high in the cycle immediately after the last stop cycle. In that cycle the FSM is in IDLE, txd_o=1 and busy_o=0.
- Back-to-back frames: the next dequeue may occur in that same IDLE cycle. The inter-frame gap is therefore exactly 1 extra high cycle beyond the stop bits.
- CTS latency: cts_n_i sampled low at edges E1 and E2 allows fifo_rdeq_o in the cycle after E2, if the FIFO is non-empty.
- busy_o is registered and equals (state != IDLE).

## Test plan
- Basic frame: reset; baud_div=3, no parity, 1 stop, FIFO holds 0x55, cts_n=0.
  - Exactly one rdeq pulse.
  - txd: 4 clk low, then bit pattern 1,0,1,0,1,0,1,0 at 4 clk each, then 4 clk high.
  - Frame length 40 clk; frame_done pulses once; busy falls with it.
- Parity and stop bits: baud_div=1.
  - Byte 0x07, even parity: parity bit=1.
  - Byte 0x07, odd parity: parity bit=0.
  - two_stop=1: stop high lasts 4 clk.
  - Total frame 24 clk.
- Back-to-back: FIFO holds 0xA5 then 0x3C.
  - The second rdeq occurs in the frame_done cycle.
  - The second start bit begins on the next edge.
  - Both byte patterns are correct on txd.
- Flow control: cts_n=1 with FIFO non-empty.
  - No rdeq and txd stays high for 100 clk.
  - Drive cts_n=0: rdeq appears after exactly 2 sync edges.
  - Raise cts_n during bit 3: the frame completes, and no further rdeq while cts_n=1.
- Reset mid-frame: assert resetn=0 during data bit 4.
  - Next cycle: txd=1, busy=0, frame_done=0.
  - After release, the next FIFO byte transmits normally.
- Minimum divisor and config latching: baud_div=0 gives a 10-clk frame for 0xFF.
  - Changing baud_div to 7 mid-frame leaves the current frame at 1 clk/bit.
  - The next frame uses 8 clk/bit.
